// File: rtl/mul32_seq_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
// The divider can reuse the width constants from here.
`ifndef MUL32_SEQ_PKG_SV
`define MUL32_SEQ_PKG_SV
package mul32_seq_pkg;

  localparam int MUL_W     = 32;
  localparam int MUL_ITER  = 32;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_FIX  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

endpackage
`endif

// File: rtl/mul32_seq_abs32.sv
// Optional two's-complement magnitude: 0x8000_0000 maps to itself,
// which is the correct unsigned magnitude.
module abs32
  import mul32_seq_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] mag_o,
  output logic         neg_o
);

  assign neg_o = en_i & val_i[W-1];
  assign mag_o = neg_o ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul32_seq.sv
// Radix-2 shift-add multiplier, one bit per clock, fixed latency.
// Product packed {hi, lo} for the HI/LO registers.
module mul32_seq
  import mul32_seq_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  mul_state_e             state_q;
  logic [WIDTH-1:0]       mcand_q;
  logic [WIDTH-1:0]       mplier_q;
  logic [WIDTH:0]         acc_q;
  logic [MUL_CNT_W-1:0]   cnt_q;
  logic                   neg_q;
  logic [2*WIDTH-1:0]     prod_q;
  logic                   in_ready_q;
  logic                   out_valid_q;

  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;
  logic                   a_neg;
  logic                   b_neg;

  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         acc_d;
  logic [WIDTH-1:0]       mplier_d;
  logic [MUL_CNT_W-1:0]   cnt_d;
  logic [2*WIDTH-1:0]     p_mag;

  abs32 #(.W(WIDTH)) u_abs_a (
    .val_i (a),
    .en_i  (sgn),
    .mag_o (a_mag),
    .neg_o (a_neg)
  );

  abs32 #(.W(WIDTH)) u_abs_b (
    .val_i (b),
    .en_i  (sgn),
    .mag_o (b_mag),
    .neg_o (b_neg)
  );

  // acc never exceeds WIDTH bits after a shift, so the add cannot
  // overflow the WIDTH+1 bit register.
  assign sum      = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_d    = {1'b0, sum[WIDTH:1]};
  assign mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
  assign cnt_d    = cnt_q + MUL_CNT_W'(1);
  assign p_mag    = {acc_q[WIDTH-1:0], mplier_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MUL_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (in_valid) begin
            mcand_q    <= a_mag;
            mplier_q   <= b_mag;
            neg_q      <= a_neg ^ b_neg;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL_CALC;
          end
        end
        MUL_CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (cnt_q == MUL_CNT_W'(MUL_ITER - 1)) begin
            state_q <= MUL_FIX;
          end
        end
        MUL_FIX: begin
          prod_q      <= neg_q ? (~p_mag + 64'd1) : p_mag;
          out_valid_q <= 1'b1;
          state_q     <= MUL_DONE;
        end
        MUL_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= MUL_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed table, handshake corner sequences and a short random
// run against a behavioural 64-bit product.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] prod;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mul32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Caller sits 1 time unit after a rising edge.
  task automatic mul_req(input logic [31:0] xa,
                         input logic [31:0] xb,
                         input logic xs,
                         input int stall,
                         input logic [63:0] exp,
                         input string nm);
    int lat;
    chk({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
    a = xa;
    b = xb;
    sgn = xs;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " prod"}, prod, exp);
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    if (stall > 0) begin
      chk({nm, " held"}, {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, " drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    int bad;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs[0] = '{32'h0000_0007, 32'h0000_0006, 1'b0,
                64'h0000_0000_0000_002A};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'hFFFF_FFFD, 32'h0000_0005, 1'b1,
                64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1,
                64'h4000_0000_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                64'h0000_0000_0000_0001};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1,
                64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                64'h0000_0000_8000_0000};
    vecs[7] = '{32'h0000_0000, 32'h1234_5678, 1'b0,
                64'h0000_0000_0000_0000};
    vecs[8] = '{32'h0001_0000, 32'h0001_0000, 1'b0,
                64'h0000_0001_0000_0000};
    vecs[9] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1,
                64'h3FFF_FFFF_0000_0001};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sgn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst prod", prod, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      mul_req(vecs[i].a, vecs[i].b, vecs[i].s, 0, vecs[i].p,
              $sformatf("vec%0d", i));
    end

    // Backpressure with ignored requests during CALC and DONE.
    a = 32'd7;
    b = 32'd6;
    sgn = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 100) begin
      a = $urandom;
      b = $urandom;
      sgn = lat[0];
      in_valid = 1'b1;
      if (in_ready) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd33);
    chk("bp calc in_ready", 64'(bad), 64'd0);
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      chk("bp valid", {63'd0, out_valid}, 64'd1);
      chk("bp prod", prod, 64'd42);
      chk("bp in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp drop", {63'd0, out_valid}, 64'd0);
    chk("bp no accept", {63'd0, in_ready}, 64'd1);
    chk("bp prod kept", prod, 64'd42);

    // Reset at the tenth edge after acceptance.
    a = 32'd7;
    b = 32'd6;
    sgn = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid rst prod", prod, 64'd0);
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    chk("mid rst no pulse", 64'(bad), 64'd0);
    mul_req(32'd2, 32'd3, 1'b0, 0, 64'd6, "post rst");

    for (int i = 0; i < 250; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1));
      if (i % 16 == 0) ra = 32'h8000_0000;
      if (i % 16 == 1) rb = 32'hFFFF_FFFF;
      if (i % 16 == 2) rb = 32'd0;
      mul_req(ra, rb, rs, int'($urandom_range(3)),
              ref_mul(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
